axis_dma_pkt_checker: RTL and testbench

//  Sink-side checker downstream of the DMA slave AXI4-Stream command/data pair.
//  - Accepts one command descriptor, then consumes the matching data packet.
//  - Checks byte length, tlast placement and tkeep, then emits one status word per packet.
//  - Keeps saturating good/bad packet counters for register readback.

---
 rtl/axis_dma_pkt_checker.sv | 147 ++++++++++++++
 tb/tb_axis_dma_pkt_checker.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/axis_dma_pkt_checker.sv
// rtl/axis_dma_pkt_checker.sv - checks DMA data packets against their command descriptor length
// Emits one status word per packet and keeps saturating good/bad packet counters.
module axis_dma_pkt_checker #(
  parameter int CDWIDTH = 256,
  parameter int DWIDTH  = 512,
  parameter int KWIDTH  = 64,
  parameter int LEN_LSB = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_tvalid,
  output logic               cmd_tready,
  input  logic [CDWIDTH-1:0] cmd_tdata,
  input  logic               dat_tvalid,
  output logic               dat_tready,
  input  logic [DWIDTH-1:0]  dat_tdata,
  input  logic [KWIDTH-1:0]  dat_tkeep,
  input  logic               dat_tlast,
  output logic               sts_valid,
  input  logic               sts_ready,
  output logic [31:0]        sts_data,
  output logic [31:0]        pkt_ok_cnt,
  output logic [31:0]        pkt_err_cnt
);

  localparam int LOG2K = $clog2(KWIDTH);

  typedef enum logic [1:0] {IDLE, DATA, STS} state_t;

  state_t              state, state_nxt;
  logic                live;
  logic [16:0]         exp_beats;
  logic [KWIDTH-1:0]   last_mask;
  logic [10:0]         beat_cnt;
  logic [16:0]         byte_cnt;
  logic                early_last, late_last, keep_err, zero_len;

  logic [15:0]         cmd_len;
  logic [LOG2K-1:0]    cmd_rem;
  logic                cmd_hs, dat_hs, sts_hs;
  logic [16:0]         cur_beat;
  logic [17:0]         byte_sum;
  logic                any_err;
  logic                unused_bits;

  function automatic logic [LOG2K:0] popcount(input logic [KWIDTH-1:0] k);
    logic [LOG2K:0] c;
    c = '0;
    for (int i = 0; i < KWIDTH; i++) c = c + (LOG2K+1)'(k[i]);
    return c;
  endfunction

  // Low-aligned mask of rem ones; rem==0 means the final beat is full.
  function automatic logic [KWIDTH-1:0] tail_mask(input logic [LOG2K-1:0] rem);
    logic [KWIDTH-1:0] m;
    for (int i = 0; i < KWIDTH; i++) m[i] = (rem == '0) || (LOG2K'(i) < rem);
    return m;
  endfunction

  assign cmd_len     = cmd_tdata[LEN_LSB +: 16];
  assign cmd_rem     = cmd_len[LOG2K-1:0];
  assign cmd_hs      = cmd_tvalid && cmd_tready;
  assign dat_hs      = dat_tvalid && dat_tready;
  assign sts_hs      = sts_valid && sts_ready;
  assign cur_beat    = {6'd0, beat_cnt} + 17'd1;
  assign byte_sum    = {1'b0, byte_cnt} + 18'(popcount(dat_tkeep));
  assign any_err     = early_last || late_last || keep_err || zero_len;
  assign unused_bits = ^{dat_tdata, cmd_tdata};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    cmd_tready = 1'b0;
    dat_tready = 1'b0;
    sts_valid  = 1'b0;
    sts_data   = 32'd0;
    case (state)
      IDLE: begin
        cmd_tready = live;
        if (cmd_hs) state_nxt = (cmd_len == 16'd0) ? STS : DATA;
      end
      DATA: begin
        dat_tready = 1'b1;
        if (dat_hs && dat_tlast) state_nxt = STS;
      end
      STS: begin
        sts_valid = 1'b1;
        sts_data  = {12'd0, zero_len, keep_err, late_last, early_last,
                     byte_cnt[16] ? 16'hFFFF : byte_cnt[15:0]};
        if (sts_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // live keeps cmd_tready low for the cycle the reset is applied.
  always_ff @(posedge clk) begin
    if (rst) begin
      live        <= 1'b0;
      exp_beats   <= '0;
      last_mask   <= '0;
      beat_cnt    <= '0;
      byte_cnt    <= '0;
      early_last  <= 1'b0;
      late_last   <= 1'b0;
      keep_err    <= 1'b0;
      zero_len    <= 1'b0;
      pkt_ok_cnt  <= '0;
      pkt_err_cnt <= '0;
    end else begin
      live <= 1'b1;
      if (cmd_hs) begin
        exp_beats  <= 17'(cmd_len >> LOG2K) + {16'd0, cmd_rem != '0};
        last_mask  <= tail_mask(cmd_rem);
        beat_cnt   <= '0;
        byte_cnt   <= '0;
        early_last <= 1'b0;
        late_last  <= 1'b0;
        keep_err   <= 1'b0;
        zero_len   <= (cmd_len == 16'd0);
      end
      if (dat_hs) begin
        if (beat_cnt != 11'h7FF) beat_cnt <= beat_cnt + 11'd1;
        byte_cnt <= byte_sum[17] ? 17'h1FFFF : byte_sum[16:0];
        if (cur_beat < exp_beats) begin
          if (dat_tkeep != {KWIDTH{1'b1}}) keep_err <= 1'b1;
          if (dat_tlast) early_last <= 1'b1;
        end else if (cur_beat == exp_beats) begin
          if (dat_tkeep != last_mask) keep_err <= 1'b1;
          if (!dat_tlast) late_last <= 1'b1;
        end
      end
      if (sts_hs) begin
        if (any_err) begin
          if (pkt_err_cnt != 32'hFFFFFFFF) pkt_err_cnt <= pkt_err_cnt + 32'd1;
        end else begin
          if (pkt_ok_cnt != 32'hFFFFFFFF) pkt_ok_cnt <= pkt_ok_cnt + 32'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_dma_pkt_checker.sv
// tb/tb_axis_dma_pkt_checker.sv - directed bench for axis_dma_pkt_checker
// Inputs change and outputs are sampled on the falling edge.
module tb_axis_dma_pkt_checker;

  localparam int CDWIDTH = 256;
  localparam int DWIDTH  = 512;
  localparam int KWIDTH  = 64;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic               clk = 1'b0;
  logic               rst;
  logic               cmd_tvalid;
  logic               cmd_tready;
  logic [CDWIDTH-1:0] cmd_tdata;
  logic               dat_tvalid;
  logic               dat_tready;
  logic [DWIDTH-1:0]  dat_tdata;
  logic [KWIDTH-1:0]  dat_tkeep;
  logic               dat_tlast;
  logic               sts_valid;
  logic               sts_ready;
  logic [31:0]        sts_data;
  logic [31:0]        pkt_ok_cnt;
  logic [31:0]        pkt_err_cnt;

  int tests  = 0;
  int failed = 0;

  axis_dma_pkt_checker #(
    .CDWIDTH(CDWIDTH), .DWIDTH(DWIDTH), .KWIDTH(KWIDTH), .LEN_LSB(0)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_tvalid(cmd_tvalid), .cmd_tready(cmd_tready), .cmd_tdata(cmd_tdata),
    .dat_tvalid(dat_tvalid), .dat_tready(dat_tready), .dat_tdata(dat_tdata),
    .dat_tkeep(dat_tkeep), .dat_tlast(dat_tlast),
    .sts_valid(sts_valid), .sts_ready(sts_ready), .sts_data(sts_data),
    .pkt_ok_cnt(pkt_ok_cnt), .pkt_err_cnt(pkt_err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic [15:0] len);
    int n = 0;
    cmd_tdata       = '0;
    cmd_tdata[15:0] = len;
    cmd_tvalid      = 1'b1;
    while (!cmd_tready && n < 50) begin @(negedge clk); n++; end
    check("cmd_accept", {31'd0, cmd_tready}, 32'd1);
    @(negedge clk);
    cmd_tvalid = 1'b0;
  endtask

  task automatic send_beat(input logic [63:0] keep, input logic last);
    int n = 0;
    dat_tvalid = 1'b1;
    dat_tkeep  = keep;
    dat_tlast  = last;
    dat_tdata  = {16{$urandom}};
    while (!dat_tready && n < 50) begin @(negedge clk); n++; end
    check("dat_accept", {31'd0, dat_tready}, 32'd1);
    @(negedge clk);
    dat_tvalid = 1'b0;
    dat_tlast  = 1'b0;
  endtask

  task automatic recv_sts(input logic [31:0] exp_sts, input logic [31:0] exp_ok,
                          input logic [31:0] exp_err);
    int n = 0;
    while (!sts_valid && n < 50) begin @(negedge clk); n++; end
    check("sts_valid", {31'd0, sts_valid}, 32'd1);
    check("sts_data", sts_data, exp_sts);
    sts_ready = 1'b1;
    @(negedge clk);
    sts_ready = 1'b0;
    check("cmd_ready_after_sts", {31'd0, cmd_tready}, 32'd1);
    check("pkt_ok_cnt", pkt_ok_cnt, exp_ok);
    check("pkt_err_cnt", pkt_err_cnt, exp_err);
  endtask

  task automatic check_reset_outputs();
    check("rst_cmd_tready", {31'd0, cmd_tready}, 32'd0);
    check("rst_dat_tready", {31'd0, dat_tready}, 32'd0);
    check("rst_sts_valid", {31'd0, sts_valid}, 32'd0);
    check("rst_sts_data", sts_data, 32'd0);
    check("rst_ok_cnt", pkt_ok_cnt, 32'd0);
    check("rst_err_cnt", pkt_err_cnt, 32'd0);
  endtask

  initial begin
    logic [31:0] held;
    rst = 1'b1; cmd_tvalid = 1'b0; cmd_tdata = '0; dat_tvalid = 1'b0;
    dat_tdata = '0; dat_tkeep = '0; dat_tlast = 1'b0; sts_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    @(negedge clk);
    check("idle_cmd_tready", {31'd0, cmd_tready}, 32'd1);

    // len=128: two full beats, clean
    send_cmd(16'd128);
    check("dat_latency", {31'd0, dat_tready}, 32'd1);
    check("cmd_stall_in_data", {31'd0, cmd_tready}, 32'd0);
    send_beat(ONES, 1'b0);
    send_beat(ONES, 1'b1);
    check("sts_latency", {31'd0, sts_valid}, 32'd1);
    recv_sts(32'h0000_0080, 32'd1, 32'd0);

    // len=100: partial last beat of 36 bytes
    send_cmd(16'd100);
    send_beat(ONES, 1'b0);
    send_beat(64'h0000_000F_FFFF_FFFF, 1'b1);
    recv_sts(32'h0000_0064, 32'd2, 32'd0);

    // len=192: tlast one beat early
    send_cmd(16'd192);
    send_beat(ONES, 1'b0);
    send_beat(ONES, 1'b1);
    recv_sts(32'h0001_0080, 32'd2, 32'd1);

    // len=64: tlast two beats late, extra beats drained
    send_cmd(16'd64);
    send_beat(ONES, 1'b0);
    send_beat(ONES, 1'b0);
    send_beat(ONES, 1'b1);
    recv_sts(32'h0002_00C0, 32'd2, 32'd2);

    // len=128 with a hole in the first beat
    send_cmd(16'd128);
    send_beat(64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
    send_beat(ONES, 1'b1);
    recv_sts(32'h0004_007F, 32'd2, 32'd3);

    // len=0: straight to status, held off for 10 cycles
    send_cmd(16'd0);
    check("zero_len_no_dat_tready", {31'd0, dat_tready}, 32'd0);
    held = sts_data;
    check("zero_len_sts", held, 32'h0008_0000);
    cmd_tvalid = 1'b1;
    repeat (10) @(negedge clk);
    check("zero_len_hold_sts", sts_data, 32'h0008_0000);
    check("zero_len_hold_cmd_stall", {31'd0, cmd_tready}, 32'd0);
    check("zero_len_hold_dat_stall", {31'd0, dat_tready}, 32'd0);
    cmd_tvalid = 1'b0;
    recv_sts(32'h0008_0000, 32'd2, 32'd4);

    // reset after one beat of a packet abandons it
    send_cmd(16'd128);
    send_beat(ONES, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    @(negedge clk);
    send_cmd(16'd64);
    send_beat(ONES, 1'b1);
    recv_sts(32'h0000_0040, 32'd1, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
